// File: rtl/bf16_tx_pkg.sv
// Shared types and constants for the bf16 byte transmitter.
package bf16_tx_pkg;

    localparam int BF16_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        CK_LO,
        CK_HI
    } tx_state_t;

    // Occupancy counter width: must be able to represent DEPTH itself.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bf16_sync_fifo.sv
// Single-clock FIFO of bf16 words with combinational head read.
// A push on a full FIFO is still accepted when a pop happens in the same cycle.
module bf16_sync_fifo
    import bf16_tx_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LVL_W = level_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [BF16_W-1:0] wdata,
    output logic [BF16_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [BF16_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the data array is not reset; empty/level already mask stale entries.
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bf16_byte_tx.sv
// Buffers a valid-only stream of bf16 words (bits [31:16]) and sends each as
// two bytes, low byte first, over a ready/valid byte link framed per tensor.
// Define BF16_TX_CHECKSUM_EN to append a 16-bit running sum (low byte, then
// high byte) after the last element of every frame.
module bf16_byte_tx
    import bf16_tx_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 49152,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_tvalid,
    input  logic [31:0]                 s_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic [BYTE_W-1:0]           m_tdata,
    output logic                        m_tlast,
    output logic                        frame_done,
    output logic                        overflow,
    output logic [level_w(DEPTH)-1:0]   fifo_level
);

    tx_state_t         state, state_nxt;
    logic [BF16_W-1:0] hold, hold_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BYTE_W-1:0] tdata_nxt;
    logic              tvalid_nxt;
    logic              tlast_nxt;
    logic              done_nxt;
    logic              load_next;
    logic              pop;
    logic [BF16_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              hs;
    logic              last_elem;
    logic              unused_low_half;
`ifdef BF16_TX_CHECKSUM_EN
    logic [BF16_W-1:0] sum, sum_nxt;
`endif

    assign hs              = m_tvalid && m_tready;
    assign last_elem       = (cnt == CNT_W'(FRAME_LEN - 1));
    assign unused_low_half = ^s_tdata[15:0];

    bf16_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_tvalid),
        .pop   (pop),
        .wdata (s_tdata[31:16]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Next-state and next-output decode for the byte serialiser.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt  = state;
        hold_nxt   = hold;
        cnt_nxt    = cnt;
        tdata_nxt  = m_tdata;
        tvalid_nxt = m_tvalid;
        tlast_nxt  = m_tlast;
        done_nxt   = 1'b0;
        load_next  = 1'b0;
        pop        = 1'b0;
`ifdef BF16_TX_CHECKSUM_EN
        sum_nxt    = sum;
`endif
        case (state)
            IDLE: load_next = 1'b1;
            LO: begin
                if (hs) begin
                    tdata_nxt = hold[BYTE_W +: BYTE_W];
`ifdef BF16_TX_CHECKSUM_EN
                    tlast_nxt = 1'b0;
`else
                    tlast_nxt = last_elem;
`endif
                    state_nxt = HI;
                end
            end
            HI: begin
                if (hs) begin
`ifdef BF16_TX_CHECKSUM_EN
                    sum_nxt = sum + hold;
                    if (last_elem) begin
                        cnt_nxt   = '0;
                        tdata_nxt = sum_nxt[BYTE_W-1:0];
                        state_nxt = CK_LO;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        load_next = 1'b1;
                    end
`else
                    done_nxt  = last_elem;
                    cnt_nxt   = last_elem ? '0 : cnt + 1'b1;
                    load_next = 1'b1;
`endif
                end
            end
`ifdef BF16_TX_CHECKSUM_EN
            CK_LO: begin
                if (hs) begin
                    tdata_nxt = sum[BYTE_W +: BYTE_W];
                    tlast_nxt = 1'b1;
                    state_nxt = CK_HI;
                end
            end
            CK_HI: begin
                if (hs) begin
                    done_nxt  = 1'b1;
                    sum_nxt   = '0;
                    load_next = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        // Start the next element straight away when one is buffered, else go idle.
        if (load_next) begin
            if (!fifo_empty) begin
                pop        = 1'b1;
                hold_nxt   = fifo_rdata;
                tdata_nxt  = fifo_rdata[BYTE_W-1:0];
                tvalid_nxt = 1'b1;
                tlast_nxt  = 1'b0;
                state_nxt  = LO;
            end else begin
                tvalid_nxt = 1'b0;
                tlast_nxt  = 1'b0;
                state_nxt  = IDLE;
            end
        end
    end

    // State, output and sticky-overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            cnt        <= '0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tlast    <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
`ifdef BF16_TX_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            hold       <= hold_nxt;
            cnt        <= cnt_nxt;
            m_tvalid   <= tvalid_nxt;
            m_tdata    <= tdata_nxt;
            m_tlast    <= tlast_nxt;
            frame_done <= done_nxt;
`ifdef BF16_TX_CHECKSUM_EN
            sum        <= sum_nxt;
`endif
            if (s_tvalid && fifo_full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bf16_byte_tx.sv
// Self-checking bench for bf16_byte_tx (default build, small frame and FIFO).
module tb_bf16_byte_tx;

    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = 2;
    localparam int DRAIN_MAX = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        frame_done;
    logic        overflow;
    logic [2:0]  fifo_level;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;

    exp_t sb_q[$];
    vec_t frame_vec[4];
    vec_t ovf_vec[6];

    int n_checks = 0;
    int n_pass   = 0;
    int el_idx   = 0;
    int cyc      = 0;
    int fd_cnt   = 0;
    int first_hs = -1;
    int last_hs  = -1;
    int fd0;

    bf16_byte_tx #(
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .frame_done (frame_done),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word for one cycle; accepted words queue their two expected bytes.
    task automatic push_word(input logic [31:0] word, input bit acc, input logic [7:0] lo, input logic [7:0] hi);
        exp_t e;
        if (acc) begin
            e.data = lo; e.last = 1'b0;
            sb_q.push_back(e);
            e.data = hi; e.last = ((el_idx % FRAME_LEN) == FRAME_LEN - 1);
            sb_q.push_back(e);
            el_idx++;
        end
        s_tvalid = 1'b1;
        s_tdata  = word;
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || m_tvalid) && n < DRAIN_MAX) begin
            tick();
            n++;
        end
        check(name, 32'(n < DRAIN_MAX), 32'd1);
        tick();
        tick();
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        tick();
        rst = 1'b0;
        sb_q.delete();
        el_idx = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_tdata"}, 32'(m_tdata), 32'd0);
        check({tag, "_tlast"}, 32'(m_tlast), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_level"}, 32'(fifo_level), 32'd0);
    endtask

    // Output monitor: every accepted byte is compared with the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst && frame_done) fd_cnt++;
        if (!rst && m_tvalid && m_tready) begin
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL extra_byte: got 0x%0h last=%0d, expected no byte (t=%0t)", m_tdata, m_tlast, $time);
            end else begin
                e = sb_q.pop_front();
                check("byte_last_data", {23'd0, m_tlast, m_tdata}, {23'd0, e.last, e.data});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        frame_vec[0] = '{32'h1234_ABCD, 8'h34, 8'h12};
        frame_vec[1] = '{32'h5678_0000, 8'h78, 8'h56};
        frame_vec[2] = '{32'h9ABC_FFFF, 8'hBC, 8'h9A};
        frame_vec[3] = '{32'hDEF0_5555, 8'hF0, 8'hDE};
        ovf_vec[0]   = '{32'h0102_0000, 8'h02, 8'h01};
        ovf_vec[1]   = '{32'h0304_1111, 8'h04, 8'h03};
        ovf_vec[2]   = '{32'h0506_2222, 8'h06, 8'h05};
        ovf_vec[3]   = '{32'h0708_3333, 8'h08, 8'h07};
        ovf_vec[4]   = '{32'h090A_4444, 8'h0A, 8'h09};
        ovf_vec[5]   = '{32'h0B0C_5555, 8'h0C, 8'h0B};

        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;

        // Single word into an idle block: valid appears one edge after the push edge.
        m_tready = 1'b1;
        push_word(32'h3F80_0000, 1'b1, 8'h80, 8'h3F);
        check("single_no_valid_yet", 32'(m_tvalid), 32'd0);
        check("single_level_after_push", 32'(fifo_level), 32'd1);
        tick();
        check("single_first_valid", 32'(m_tvalid), 32'd1);
        check("single_first_byte", 32'(m_tdata), 32'h80);
        check("single_level_after_pop", 32'(fifo_level), 32'd0);
        wait_drain("single_drain");
        apply_reset();

        // One full frame from the vector table.
        fd0 = fd_cnt;
        foreach (frame_vec[i]) begin
            push_word(frame_vec[i].word, 1'b1, frame_vec[i].lo, frame_vec[i].hi);
            tick();
        end
        wait_drain("frame_drain");
        check("frame_done_once", 32'(fd_cnt - fd0), 32'd1);
        check("frame_level_empty", 32'(fifo_level), 32'd0);

        // Two frames back to back at one word per two cycles: no output bubble.
        first_hs = -1;
        fd0      = fd_cnt;
        for (int f = 0; f < 2; f++) begin
            foreach (frame_vec[i]) begin
                push_word(frame_vec[i].word, 1'b1, frame_vec[i].lo, frame_vec[i].hi);
                tick();
            end
        end
        wait_drain("b2b_drain");
        check("b2b_byte_span", 32'(last_hs - first_hs + 1), 32'd16);
        check("b2b_frame_done", 32'(fd_cnt - fd0), 32'd2);
        check("b2b_no_overflow", 32'(overflow), 32'd0);

        // Ten-cycle stall while the high byte of an element is presented.
        m_tready = 1'b0;
        push_word(frame_vec[0].word, 1'b1, frame_vec[0].lo, frame_vec[0].hi);
        tick();
        push_word(frame_vec[1].word, 1'b1, frame_vec[1].lo, frame_vec[1].hi);
        tick();
        tick();
        check("stall_lo_presented", {23'd0, m_tvalid, m_tdata}, {23'd0, 1'b1, 8'h34});
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_hold_stable", {22'd0, m_tvalid, m_tlast, m_tdata}, {22'd0, 1'b1, 1'b0, 8'h12});
            tick();
        end
        m_tready = 1'b1;
        wait_drain("stall_drain");
        apply_reset();

        // Six back-to-back words with the link stalled: one goes to the hold
        // register, four fill the FIFO, the sixth is dropped.
        m_tready = 1'b0;
        foreach (ovf_vec[i]) push_word(ovf_vec[i].word, (i < 5), ovf_vec[i].lo, ovf_vec[i].hi);
        check("ovf_level_saturated", 32'(fifo_level), 32'd4);
        check("ovf_flag_set", 32'(overflow), 32'd1);
        m_tready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_flag_sticky", 32'(overflow), 32'd1);
        check("ovf_level_empty", 32'(fifo_level), 32'd0);

        // Reset mid-frame with three words buffered, then a clean frame.
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(frame_vec[i].word, 1'b0, 8'h00, 8'h00);
        check("midrst_level_before", 32'(fifo_level), 32'd3);
        check("midrst_valid_before", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        sb_q.delete();
        el_idx   = 0;
        m_tready = 1'b1;
        fd0      = fd_cnt;
        foreach (frame_vec[i]) begin
            push_word(frame_vec[i].word, 1'b1, frame_vec[i].lo, frame_vec[i].hi);
            tick();
        end
        wait_drain("midrst_frame_drain");
        check("midrst_frame_done", 32'(fd_cnt - fd0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
